systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Downstream of the systolic array controller: after the controller's completion pulse, reads the NxN accumulator array one row at a time.
- Streams each row out as LANES-wide beats on a valid/ready interface.
- Holds drain_busy high so the next computation is not started while results are still being read.

Parameters:
- ARRAY_SIZE, 32, array dimension N (rows = columns = N).
- ACC_WIDTH, 32, width of one PE accumulator.
- OUT_WIDTH, 16, width of one output element.
- LANES, 4, elements per output beat; must divide ARRAY_SIZE.
- ROW_W, $clog2(ARRAY_SIZE) (minimum 1), row index width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- compute_done  input  1  one-cycle pulse from the controller; accumulator results are valid
- err_clr  input  1  clears overrun_err
- drain_busy  output  1  high from FETCH through DONE inclusive
- acc_rd_en  output  1  row read strobe to the array result mux
- acc_rd_row  output  ROW_W  row being read
- acc_rd_data  input  ARRAY_SIZE*ACC_WIDTH  row data, valid the cycle after acc_rd_en; column c at [c*ACC_WIDTH +: ACC_WIDTH]
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accept
- out_data  output  LANES*OUT_WIDTH  lane k = column beat*LANES+k; lane 0 in the LSBs
- out_row  output  ROW_W  row of the current beat
- out_row_last  output  1  last beat of the row
- out_last  output  1  last beat of the matrix
- drain_done  output  1  one-cycle pulse after the final beat is accepted
- overrun_err  output  1  sticky; compute_done was seen while not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, row/beat counters 0, row buffer 0, overrun_err 0. Reset asserted mid-drain aborts immediately; no partial drain_done is produced.
- FSM states: IDLE, FETCH, CAPTURE, STREAM, DONE.
  - IDLE: compute_done=1 -> FETCH; row counter=0.
  - FETCH (1 cycle): acc_rd_en=1, acc_rd_row=row -> CAPTURE.
  - CAPTURE (1 cycle): latch acc_rd_data into the row buffer; beat=0 -> STREAM.
  - STREAM: out_valid=1. On out_valid && out_ready:
    - not last beat of the row: beat++.
    - last beat, row<N-1: row++ -> FETCH.
    - last beat, row==N-1 -> DONE.
  - DONE (1 cycle): drain_done=1 -> IDLE.
- out_data, out_row, out_row_last and out_last are functions of the row buffer, row and beat only. They stay stable while out_valid && !out_ready.
- out_row_last = (beat==BEATS-1), where BEATS=ARRAY_SIZE/LANES. out_last = out_row_last && (row==N-1).
- Per-element conversion: truncate to the low OUT_WIDTH bits of the accumulator (see optional feature).
- Latency: compute_done at cycle t gives FETCH at t+1, CAPTURE at t+2, first out_valid at t+3.
- With out_ready held at 1: N*(2+BEATS) cycles from FETCH entry to the DONE cycle.
- Overrun: compute_done in any state other than IDLE is ignored and sets overrun_err. overrun_err clears on err_clr. If set and clear occur in the same cycle, set wins.
- compute_done in IDLE in the same cycle as err_clr: the drain starts and overrun_err clears.
- Row/beat counters never wrap past N-1 / BEATS-1. The FSM exits before wrapping.

Optional Feature:
- Macro RESULT_SAT_EN.
- Defined: each accumulator, treated as signed ACC_WIDTH, saturates to signed OUT_WIDTH limits ([-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]) before packing. A registered sat_seen output (1 bit, reset 0) goes high if any element saturated during the current drain; it clears on the next drain start.
- Undefined: plain truncation to the low OUT_WIDTH bits; sat_seen does not exist.

Test Plan:
- N=4, LANES=2, OUT_WIDTH=16, row r col c = r*16+c, out_ready=1, compute_done at t:
  - first beat at t+3 with data {0x0001,0x0000}.
  - 8 beats total; out_last on row 3 beat 1.
  - drain_done at t+17.
- Same setup, out_ready toggled 1,0,0,1 repeatedly -> every beat held stable while stalled; sequence of 8 beats identical to the previous case; no beat duplicated or dropped.
- compute_done pulsed during STREAM of row 1 -> overrun_err=1; drain still completes 8 beats.
  - err_clr then asserted -> overrun_err=0.
  - err_clr and a second overrun in the same cycle -> overrun_err stays 1.
- rst asserted while in STREAM row 2 -> all outputs 0 immediately, including out_valid and drain_busy.
  - A new compute_done then restarts the drain from row 0.
- RESULT_SAT_EN defined, element values 0x0001_0000 and 0xFFFE_0000 -> output lanes 0x7FFF and 0x8000; sat_seen=1.
  - Without the macro, the same elements output 0x0000 and 0x0000.
- acc_rd_en pulses exactly once per row (4 pulses); acc_rd_row sequence is 0,1,2,3.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Reads the accumulator array row by row after compute_done and streams rows as LANES-wide beats.
// Define RESULT_SAT_EN for signed saturation of each element and a sat_seen flag.
module systolic_result_drain #(
    parameter int ARRAY_SIZE = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int LANES      = 4,
    parameter int ROW_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            compute_done,
    input  logic                            err_clr,
    output logic                            drain_busy,
    output logic                            acc_rd_en,
    output logic [ROW_W-1:0]                acc_rd_row,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] acc_rd_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*OUT_WIDTH-1:0]      out_data,
    output logic [ROW_W-1:0]                out_row,
    output logic                            out_row_last,
    output logic                            out_last,
    output logic                            drain_done,
`ifdef RESULT_SAT_EN
    output logic                            sat_seen,
`endif
    output logic                            overrun_err
);

    localparam int BEATS     = ARRAY_SIZE / LANES;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = LANES * OUT_WIDTH;
    localparam int BUF_BITS  = ARRAY_SIZE * OUT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        STREAM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic                ovr_q, ovr_d;
    logic [BUF_BITS-1:0] conv_row;
    logic                row_sat;
    logic                row_is_last;
    logic                beat_is_last;

    // The buffer holds already-converted elements, so only OUT_WIDTH bits per column are kept.
`ifdef RESULT_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH-1:0] elem;
    logic                 sat_q, sat_d;

    always_comb begin
        conv_row = '0;
        row_sat  = 1'b0;
        elem     = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            elem = acc_rd_data[c*ACC_WIDTH +: ACC_WIDTH];
            if ($signed(elem) > $signed(SMAX)) begin
                conv_row[c*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                row_sat = 1'b1;
            end else if ($signed(elem) < $signed(SMIN)) begin
                conv_row[c*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                row_sat = 1'b1;
            end else begin
                conv_row[c*OUT_WIDTH +: OUT_WIDTH] = elem[OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && compute_done) sat_d = 1'b0;
        else if (state_q == CAPTURE && row_sat) sat_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign sat_seen = sat_q;
`else
    logic unused_acc_bits;

    always_comb begin
        conv_row = '0;
        row_sat  = 1'b0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            conv_row[c*OUT_WIDTH +: OUT_WIDTH] = acc_rd_data[c*ACC_WIDTH +: OUT_WIDTH];
        end
    end

    assign unused_acc_bits = ^{acc_rd_data, row_sat};
`endif

    assign row_is_last  = (row_q == ROW_W'(ARRAY_SIZE - 1));
    assign beat_is_last = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        acc_rd_en  = 1'b0;
        out_valid  = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (compute_done) begin
                    state_d = FETCH;
                    row_d   = '0;
                    beat_d  = '0;
                end
            end
            FETCH: begin
                acc_rd_en = 1'b1;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                buf_d   = conv_row;
                beat_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!beat_is_last) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else if (!row_is_last) begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                drain_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Set has priority over clear so a simultaneous overrun is never lost.
    always_comb begin
        ovr_d = ovr_q;
        if (err_clr) ovr_d = 1'b0;
        if (compute_done && state_q != IDLE) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            buf_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            ovr_q   <= ovr_d;
        end
    end

    assign drain_busy   = (state_q != IDLE);
    assign acc_rd_row   = row_q;
    assign out_data     = buf_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS];
    assign out_row      = row_q;
    assign out_row_last = beat_is_last;
    assign out_last     = beat_is_last && row_is_last;
    assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: N=4, LANES=2, 16-bit outputs.
module tb_systolic_result_drain;

    localparam int N     = 4;
    localparam int L     = 2;
    localparam int OW    = 16;
    localparam int AW    = 32;
    localparam int RW    = 2;
    localparam int BEATS = N / L;

    typedef struct packed {
        logic [RW-1:0]   row;
        logic [L*OW-1:0] data;
        logic            rl;
        logic            l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              compute_done;
    logic              err_clr;
    logic              drain_busy;
    logic              acc_rd_en;
    logic [RW-1:0]     acc_rd_row;
    logic [N*AW-1:0]   acc_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [L*OW-1:0]   out_data;
    logic [RW-1:0]     out_row;
    logic              out_row_last;
    logic              out_last;
    logic              drain_done;
    logic              overrun_err;
`ifdef RESULT_SAT_EN
    logic              sat_seen;
`endif

    systolic_result_drain #(
        .ARRAY_SIZE(N),
        .ACC_WIDTH(AW),
        .OUT_WIDTH(OW),
        .LANES(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .compute_done(compute_done),
        .err_clr(err_clr),
        .drain_busy(drain_busy),
        .acc_rd_en(acc_rd_en),
        .acc_rd_row(acc_rd_row),
        .acc_rd_data(acc_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_row(out_row),
        .out_row_last(out_row_last),
        .out_last(out_last),
        .drain_done(drain_done),
`ifdef RESULT_SAT_EN
        .sat_seen(sat_seen),
`endif
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mode  = 0;
    int          beats = 0;
    int          first_cyc = -1;
    logic [L*OW-1:0] first_data = '0;
    logic        arm_first = 1'b0;
    logic        exp_sat = 1'b0;
    logic [AW-1:0] mat [N][N];
    beat_t       exp_q[$];
    logic [RW-1:0] rd_rows[$];
    logic        hold_v = 1'b0;
    logic [RW+2+L*OW-1:0] hold_vec = '0;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference element conversion taken directly from the numeric rule.
    function automatic logic [OW-1:0] conv(input logic [AW-1:0] a);
`ifdef RESULT_SAT_EN
        int signed v;
        v = $signed(a);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return a[OW-1:0];
    endfunction

    function automatic logic is_sat(input logic [AW-1:0] a);
        int signed v;
        v = $signed(a);
        return (v > 32767) || (v < -32768);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Array result mux model: registered read, one cycle after acc_rd_en.
    always @(posedge clk) begin
        if (acc_rd_en) begin
            for (int c = 0; c < N; c++) acc_rd_data[c*AW +: AW] <= mat[acc_rd_row][c];
        end
    end

    initial begin
        int pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            pidx++;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 64'(out_valid), 1);
                chk("stall_stable", 64'({out_row, out_row_last, out_last, out_data}),
                    64'(hold_vec));
            end
            if (out_valid && arm_first) begin
                first_cyc  = cyc;
                first_data = out_data;
                arm_first  = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_expected", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_row", 64'(out_row), 64'(e.row));
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_row_last", 64'(out_row_last), 64'(e.rl));
                    chk("beat_last", 64'(out_last), 64'(e.l));
                end
                beats++;
            end
            hold_v   = out_valid && !out_ready;
            hold_vec = {out_row, out_row_last, out_last, out_data};
            if (acc_rd_en) rd_rows.push_back(acc_rd_row);
        end
    end

    task automatic push_expected();
        beat_t e;
        exp_sat = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int b = 0; b < BEATS; b++) begin
                e.row = RW'(r);
                for (int k = 0; k < L; k++) begin
                    e.data[k*OW +: OW] = conv(mat[r][b*L+k]);
                    if (is_sat(mat[r][b*L+k])) exp_sat = 1'b1;
                end
                e.rl = (b == BEATS - 1);
                e.l  = e.rl && (r == N - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = AW'(r * 16 + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = ($urandom_range(0, 1) == 1) ? $urandom
                                                        : AW'($urandom_range(0, 65535));
    endtask

    task automatic pulse(input logic cd, input logic ec, output int t);
        @(posedge clk);
        #1;
        compute_done = cd;
        err_clr      = ec;
        t            = cyc;
        @(posedge clk);
        #1;
        compute_done = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        logic got = 1'b0;
        dc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (drain_done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        chk("drain_done_seen", 64'(got), 1);
    endtask

    task automatic wait_row(input int r);
        logic got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (out_valid && out_row == RW'(r)) got = 1'b1;
        end
        chk("row_reached", 64'(got), 1);
    endtask

    task automatic check_rd_rows();
        chk("rd_pulses", 64'(rd_rows.size()), N);
        for (int i = 0; i < rd_rows.size() && i < N; i++)
            chk("rd_row_seq", 64'(rd_rows[i]), 64'(i));
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({drain_busy, acc_rd_en, out_valid, out_data, out_row,
                    out_row_last, out_last, drain_done, overrun_err});
    endfunction

    initial begin
        int t;
        int dc;
        rst = 1'b1;
        compute_done = 1'b0;
        err_clr = 1'b0;
        fill_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
`ifdef RESULT_SAT_EN
        chk("reset_sat_seen", 64'(sat_seen), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Drain 1: ramp matrix, always ready, latency and read sequence.
        rd_rows.delete();
        beats = 0;
        push_expected();
        arm_first = 1'b1;
        pulse(1'b1, 1'b0, t);
        wait_done(dc);
        chk("first_beat_cycle", 64'(first_cyc), 64'(t + 3));
        chk("first_beat_data", 64'(first_data), 64'h0001_0000);
        chk("done_cycle", 64'(dc), 64'(t + 17));
        chk("beats_d1", 64'(beats), 8);
        chk("queue_empty_d1", 64'(exp_q.size()), 0);
        check_rd_rows();
`ifdef RESULT_SAT_EN
        chk("sat_seen_d1", 64'(sat_seen), 64'(exp_sat));
`endif

        // Drain 2: same matrix with 1,0,0,1 back-pressure.
        mode = 1;
        beats = 0;
        push_expected();
        pulse(1'b1, 1'b0, t);
        wait_done(dc);
        chk("beats_d2", 64'(beats), 8);
        chk("queue_empty_d2", 64'(exp_q.size()), 0);

        // Drain 3: random data and ready, overrun during row 1, then clear.
        mode = 2;
        fill_rand();
        beats = 0;
        push_expected();
        pulse(1'b1, 1'b0, t);
        wait_row(1);
        pulse(1'b1, 1'b0, t);
        @(negedge clk);
        chk("overrun_set", 64'(overrun_err), 1);
        wait_done(dc);
        chk("beats_d3", 64'(beats), 8);
        chk("queue_empty_d3", 64'(exp_q.size()), 0);
        pulse(1'b0, 1'b1, t);
        @(negedge clk);
        chk("overrun_cleared", 64'(overrun_err), 0);

        // Drain 4: overrun and err_clr in the same cycle.
        fill_rand();
        beats = 0;
        push_expected();
        pulse(1'b1, 1'b0, t);
        wait_row(1);
        pulse(1'b1, 1'b1, t);
        @(negedge clk);
        chk("overrun_set_wins", 64'(overrun_err), 1);
        wait_done(dc);
        chk("beats_d4", 64'(beats), 8);
        chk("queue_empty_d4", 64'(exp_q.size()), 0);

        // Drain 5: start together with err_clr, then reset during row 2.
        fill_rand();
        beats = 0;
        push_expected();
        pulse(1'b1, 1'b1, t);
        @(negedge clk);
        chk("start_clears_ovr", 64'(overrun_err), 0);
        chk("start_busy", 64'(drain_busy), 1);
        wait_row(2);
        #1 rst = 1'b1;
        #1;
        chk("midreset_outputs", out_vec(), 0);
        exp_q.delete();
        rd_rows.delete();
        beats = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        push_expected();
        pulse(1'b1, 1'b0, t);
        wait_done(dc);
        chk("beats_restart", 64'(beats), 8);
        chk("queue_empty_restart", 64'(exp_q.size()), 0);
        check_rd_rows();

        // Drain 6: out-of-range elements in row 0.
        fill_ramp();
        mat[0][0] = 32'h0001_0000;
        mat[0][1] = 32'hFFFE_0000;
        beats = 0;
        push_expected();
        arm_first = 1'b1;
        pulse(1'b1, 1'b0, t);
        wait_done(dc);
`ifdef RESULT_SAT_EN
        chk("sat_first_beat", 64'(first_data), 64'h8000_7FFF);
        chk("sat_seen_d6", 64'(sat_seen), 1);
`else
        chk("trunc_first_beat", 64'(first_data), 64'h0000_0000);
`endif
        chk("beats_d6", 64'(beats), 8);
        chk("queue_empty_d6", 64'(exp_q.size()), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
